// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter that merges several writeback
// requesters onto the single register-file write port.
// Optional feature macro: RF_WB_BYPASS_EN adds regA/regB read indices and
// combinational forwarding outputs (fwd_hitA/B, fwd_dataA/B) driven from the
// staged write. The default build (macro undefined) has no forwarding ports.
//
// Handshake: requester i transfers when req_valid[i] && req_ready[i] at a
// posedge. req_ready is combinational from req_valid/req_reg/stall/reset and
// the round-robin pointer only; it never looks at req_data. Writes to r0 are
// accepted and dropped; a nonzero-destination transfer appears on the write
// port (RegWr/write_reg/write_data) for exactly one cycle after the edge.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*5-1:0]  req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
`ifdef RF_WB_BYPASS_EN
  input  logic [4:0]         regA,
  input  logic [4:0]         regB,
  output logic               fwd_hitA,
  output logic               fwd_hitB,
  output logic [DW-1:0]      fwd_dataA,
  output logic [DW-1:0]      fwd_dataB,
`endif
  output logic               RegWr,
  output logic [4:0]         write_reg,
  output logic [DW-1:0]      write_data
);

  localparam int GW = $clog2(NREQ);

  // Pointer to the most recent nonzero-destination winner.
  logic [GW-1:0]   last_grant_q, last_grant_d;
  // Staged write port.
  logic            regwr_q, regwr_d;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [DW-1:0]   write_data_q, write_data_d;

  // Arbitration results.
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] drop;
  logic            any_cand;
  logic [GW-1:0]   win;
  logic            grant_vld;

  // Classify requests: nonzero destinations compete, r0 writes are dropped.
  always_comb begin
    cand = '0;
    drop = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand[i] = req_valid[i] && (req_reg[5*i +: 5] != 5'd0);
      drop[i] = req_valid[i] && (req_reg[5*i +: 5] == 5'd0);
    end
  end

  // Round-robin search starting just above the last winner, wrapping around.
  always_comb begin
    int idx;
    any_cand = 1'b0;
    win      = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(last_grant_q) + 1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_cand && cand[idx]) begin
        any_cand = 1'b1;
        win      = GW'(idx);
      end
    end
  end

  // A grant is issued only out of reset and when the write port is not stalled.
  always_comb begin
    grant_vld = reset && !stall && any_cand;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = reset && (drop[i] || (grant_vld && (win == GW'(i))));
    end
  end

  // Next-state: stage the winner's write; otherwise hold the port values.
  always_comb begin
    last_grant_d = last_grant_q;
    regwr_d      = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant_vld) begin
      last_grant_d = win;
      regwr_d      = 1'b1;
      write_reg_d  = req_reg[5*win +: 5];
      write_data_d = req_data[DW*win +: DW];
    end
  end

  // State registers with synchronous active-low reset; requester 0 goes first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= GW'(NREQ - 1);
      regwr_q      <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      regwr_q      <= regwr_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWr      = regwr_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the staged write to matching read indices; r0 never hits.
  always_comb begin
    fwd_hitA  = regwr_q && (write_reg_q == regA) && (regA != 5'd0);
    fwd_hitB  = regwr_q && (write_reg_q == regB) && (regB != 5'd0);
    fwd_dataA = fwd_hitA ? write_data_q : '0;
    fwd_dataB = fwd_hitB ? write_data_q : '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (NREQ=3, DW=32).
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;

  logic               clk;
  logic               reset;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*5-1:0]  req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               RegWr;
  logic [4:0]         write_reg;
  logic [DW-1:0]      write_data;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]         regA, regB;
  logic               fwd_hitA, fwd_hitB;
  logic [DW-1:0]      fwd_dataA, fwd_dataB;
`endif

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
`ifdef RF_WB_BYPASS_EN
    .regA       (regA),
    .regB       (regB),
    .fwd_hitA   (fwd_hitA),
    .fwd_hitB   (fwd_hitB),
    .fwd_dataA  (fwd_dataA),
    .fwd_dataB  (fwd_dataB),
`endif
    .RegWr      (RegWr),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_reg[5*i +: 5]     = r;
    req_data[DW*i +: DW]  = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    clear_reqs();
`ifdef RF_WB_BYPASS_EN
    regA = 5'd0;
    regB = 5'd0;
`endif

    // ---- Reset state, and no acceptance during reset ----
    tick();
    tick();
    chk("rst_regwr", 64'(RegWr), 64'd0);
    chk("rst_wreg", 64'(write_reg), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    set_req(0, 1'b1, 5'd0, 32'h0000_00AA);
    set_req(1, 1'b1, 5'd3, 32'h0000_00BB);
    settle();
    chk("rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("rst_no_write", 64'(RegWr), 64'd0);

    // ---- Round-robin 0,1,2 with back-to-back writes ----
    reset = 1'b1;
    set_req(0, 1'b1, 5'd5, 32'hA000_0000);
    set_req(1, 1'b1, 5'd5, 32'hA000_0001);
    set_req(2, 1'b1, 5'd5, 32'hA000_0002);
    settle();
    chk("rr_ready0", 64'(req_ready), 64'b001);
    tick();
    chk("rr_regwr0", 64'(RegWr), 64'd1);
    chk("rr_wreg0", 64'(write_reg), 64'd5);
    chk("rr_wdata0", 64'(write_data), 64'hA000_0000);
    chk("rr_ready1", 64'(req_ready), 64'b010);
    tick();
    chk("rr_regwr1", 64'(RegWr), 64'd1);
    chk("rr_wdata1", 64'(write_data), 64'hA000_0001);
    chk("rr_ready2", 64'(req_ready), 64'b100);
    tick();
    chk("rr_regwr2", 64'(RegWr), 64'd1);
    chk("rr_wdata2", 64'(write_data), 64'hA000_0002);
    clear_reqs();
    tick();
    chk("idle_regwr", 64'(RegWr), 64'd0);
    chk("idle_hold_wreg", 64'(write_reg), 64'd5);
    chk("idle_hold_wdata", 64'(write_data), 64'hA000_0002);

    // ---- r0 drop alongside a real write (last_grant was 2) ----
    set_req(0, 1'b1, 5'd0, 32'h5555_5555);
    set_req(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
    settle();
    chk("zero_ready", 64'(req_ready), 64'b011);
    tick();
    chk("zero_regwr", 64'(RegWr), 64'd1);
    chk("zero_wreg", 64'(write_reg), 64'd7);
    chk("zero_wdata", 64'(write_data), 64'hDEAD_BEEF);
    // last_grant is now 1, so with everyone competing requester 2 wins.
    clear_reqs();
    set_req(0, 1'b1, 5'd3, 32'h1);
    set_req(1, 1'b1, 5'd3, 32'h2);
    set_req(2, 1'b1, 5'd3, 32'h3);
    settle();
    chk("lastgrant_ready", 64'(req_ready), 64'b100);
    // Data must not influence the ready decision.
    req_data = {32'hFFFF_FFFF, 32'h0, 32'h1234_0000};
    settle();
    chk("data_indep_ready", 64'(req_ready), 64'b100);
    clear_reqs();
    tick();
    chk("after_drop_regwr", 64'(RegWr), 64'd0);

    // ---- Stall blocks grants but not r0 drops ----
    stall = 1'b1;
    set_req(0, 1'b1, 5'd0, 32'h7777_7777);
    set_req(2, 1'b1, 5'd9, 32'h0000_0900);
    settle();
    chk("stall_ready_a", 64'(req_ready), 64'b001);
    tick();
    chk("stall_regwr_a", 64'(RegWr), 64'd0);
    chk("stall_ready_b", 64'(req_ready), 64'b001);
    tick();
    chk("stall_regwr_b", 64'(RegWr), 64'd0);
    stall = 1'b0;
    settle();
    chk("unstall_ready", 64'(req_ready), 64'b101);
    tick();
    chk("unstall_regwr", 64'(RegWr), 64'd1);
    chk("unstall_wreg", 64'(write_reg), 64'd9);
    chk("unstall_wdata", 64'(write_data), 64'h0000_0900);
    clear_reqs();

    // ---- Reset mid-stream discards the staged write ----
    set_req(1, 1'b1, 5'd12, 32'hC0DE_0001);
    settle();
    chk("pre_rst_ready", 64'(req_ready), 64'b010);
    tick();
    chk("pre_rst_regwr", 64'(RegWr), 64'd1);
    clear_reqs();
    set_req(2, 1'b1, 5'd12, 32'hC0DE_0002);
    reset = 1'b0;
    settle();
    chk("mid_rst_ready", 64'(req_ready), 64'b000);
    tick();
    chk("mid_rst_regwr", 64'(RegWr), 64'd0);
    chk("mid_rst_wreg", 64'(write_reg), 64'd0);
    chk("mid_rst_wdata", 64'(write_data), 64'd0);
    reset = 1'b1;
    set_req(0, 1'b1, 5'd12, 32'hC0DE_0000);
    set_req(1, 1'b1, 5'd12, 32'hC0DE_0001);
    settle();
    chk("post_rst_ready", 64'(req_ready), 64'b001);
    tick();
    chk("post_rst_wdata", 64'(write_data), 64'hC0DE_0000);
    // Requester 1 still waiting is next.
    chk("post_rst_ready2", 64'(req_ready), 64'b010);
    clear_reqs();
    tick();

`ifdef RF_WB_BYPASS_EN
    // ---- Forwarding from the staged write ----
    set_req(0, 1'b1, 5'd4, 32'h1234_5678);
    tick();
    clear_reqs();
    regA = 5'd4;
    regB = 5'd0;
    settle();
    chk("fwd_hitA", 64'(fwd_hitA), 64'd1);
    chk("fwd_dataA", 64'(fwd_dataA), 64'h1234_5678);
    chk("fwd_hitB", 64'(fwd_hitB), 64'd0);
    chk("fwd_dataB", 64'(fwd_dataB), 64'd0);
    regA = 5'd5;
    regB = 5'd4;
    settle();
    chk("fwd_missA", 64'(fwd_hitA), 64'd0);
    chk("fwd_missA_data", 64'(fwd_dataA), 64'd0);
    chk("fwd_hitB2", 64'(fwd_hitB), 64'd1);
    tick();
    chk("fwd_noregwr", 64'(fwd_hitB), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
